// File: rtl/core_ifu_if.sv
// Shared types and bus interfaces for the instruction fetch unit.
//   core_ifu_pkg : PC/IR widths and the dispatch request/response packets.
//   ifetch_if    : fetch port. The master issues req_pc with req_vld/req_rdy and
//                  takes rsp_ir with rsp_vld/rsp_rdy. Responses come back in request order.
//   iexec_if     : dispatch port. The master offers req_pkt with req_vld/req_rdy.
//                  The slave returns rsp_pkt {taken, offset} in the handshake cycle.
package core_ifu_pkg;
  localparam int unsigned RV_PC_SIZE = 32'd32;
  localparam int unsigned RV_IR_SIZE = 32'd32;

  typedef struct packed {
    logic [RV_IR_SIZE-1:0] ir;
    logic [RV_PC_SIZE-1:0] pc;
    logic                  valid;
  } iexec_req_t;

  typedef struct packed {
    logic                  taken;
    logic [RV_PC_SIZE-1:0] offset;
  } iexec_rsp_t;
endpackage

interface ifetch_if;
  logic                               req_vld;
  logic                               req_rdy;
  logic [core_ifu_pkg::RV_PC_SIZE-1:0] req_pc;
  logic                               rsp_vld;
  logic                               rsp_rdy;
  logic [core_ifu_pkg::RV_IR_SIZE-1:0] rsp_ir;

  modport master (output req_vld, req_pc, rsp_rdy, input req_rdy, rsp_vld, rsp_ir);
  modport slave  (input req_vld, req_pc, rsp_rdy, output req_rdy, rsp_vld, rsp_ir);
endinterface

interface iexec_if;
  logic                     req_vld;
  logic                     req_rdy;
  core_ifu_pkg::iexec_req_t req_pkt;
  core_ifu_pkg::iexec_rsp_t rsp_pkt;

  modport master (output req_vld, req_pkt, input req_rdy, rsp_pkt);
  modport slave  (input req_vld, req_pkt, output req_rdy, rsp_pkt);
endinterface

// File: rtl/core_ifu.sv
// core_ifu: instruction fetch unit between PC generation and execute.
// Fetches sequential instruction words into a DEPTH-entry in-order buffer and
// dispatches them to execute. A taken branch reported at dispatch flushes the
// buffer, redirects the PC, and discards every wrong-path response still in flight.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset
//   ifetch : ifetch_if.master - fetch requests out, instruction words back
//   iexec  : iexec_if.master  - {ir, pc, valid} out, {taken, offset} back
module core_ifu
  import core_ifu_pkg::*;
#(
  parameter logic [RV_PC_SIZE-1:0] RESET_PC = {RV_PC_SIZE{1'b0}},
  parameter int                    DEPTH    = 2
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master ifetch,
  iexec_if.master  iexec
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [RV_PC_SIZE-1:0] PC_STEP = {{(RV_PC_SIZE-3){1'b0}}, 3'd4};

  // Buffer storage and pointers
  logic [RV_PC_SIZE-1:0] ent_pc_r [DEPTH];
  logic [RV_IR_SIZE-1:0] ent_ir_r [DEPTH];
  logic [DEPTH-1:0]      ent_filled_r;
  logic [PW-1:0]         head_r;
  logic [PW-1:0]         tail_r;
  logic [CW-1:0]         occ_r;   // allocated entries
  logic [CW-1:0]         pend_r;  // allocated entries still waiting for their word
  logic [CW-1:0]         drop_r;  // wrong-path responses still to be discarded
  logic [RV_PC_SIZE-1:0] pc_r;

  logic                  fetch_vld_s;
  logic                  fetch_fire_s;
  logic                  rsp_drop_s;
  logic                  rsp_fill_s;
  logic                  pop_s;
  logic                  redirect_s;
  logic [PW-1:0]         fill_idx_s;
  logic [CW:0]           credit_s;
  logic [RV_PC_SIZE-1:0] target_s;
  logic [DEPTH-1:0]      filled_nxt_s;
  logic [PW-1:0]         head_nxt_s;
  logic [PW-1:0]         tail_nxt_s;
  logic [CW-1:0]         occ_nxt_s;
  logic [CW-1:0]         pend_nxt_s;
  logic [CW-1:0]         drop_nxt_s;
  logic [RV_PC_SIZE-1:0] pc_nxt_s;

  // Credit covers buffered entries plus responses that will be dropped, so a
  // response always finds a slot and rsp_rdy can stay high.
  assign credit_s     = {1'b0, occ_r} + {1'b0, drop_r};
  assign fetch_vld_s  = (credit_s < (CW+1)'(DEPTH)) && !rst;
  assign fetch_fire_s = fetch_vld_s && ifetch.req_rdy;
  assign rsp_drop_s   = ifetch.rsp_vld && (drop_r != {CW{1'b0}});
  assign rsp_fill_s   = ifetch.rsp_vld && (drop_r == {CW{1'b0}});
  assign pop_s        = ent_filled_r[head_r] && iexec.req_rdy;
  assign redirect_s   = pop_s && iexec.rsp_pkt.taken;
  // Unfilled entries are the youngest pend_r ones, so the oldest sits pend_r behind tail.
  assign fill_idx_s   = tail_r - pend_r[PW-1:0];
  assign target_s     = ent_pc_r[head_r] + iexec.rsp_pkt.offset;

  assign ifetch.req_vld = fetch_vld_s;
  assign ifetch.req_pc  = pc_r;
  assign ifetch.rsp_rdy = 1'b1;
  assign iexec.req_vld  = ent_filled_r[head_r];

  // Dispatch packet: head entry when filled, all-zero otherwise
  always_comb begin
    iexec.req_pkt = '0;
    if (ent_filled_r[head_r]) begin
      iexec.req_pkt.ir    = ent_ir_r[head_r];
      iexec.req_pkt.pc    = ent_pc_r[head_r];
      iexec.req_pkt.valid = 1'b1;
    end else begin
      iexec.req_pkt = '0;
    end
  end

  // Per-entry filled flags: flush clears all; otherwise pop/alloc clear, fill sets
  always_comb begin
    filled_nxt_s = ent_filled_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (redirect_s) begin
        filled_nxt_s[i] = 1'b0;
      end else if (pop_s && (head_r == PW'(i))) begin
        filled_nxt_s[i] = 1'b0;
      end else if (fetch_fire_s && (tail_r == PW'(i))) begin
        filled_nxt_s[i] = 1'b0;
      end else if (rsp_fill_s && (fill_idx_s == PW'(i))) begin
        filled_nxt_s[i] = 1'b1;
      end else begin
        filled_nxt_s[i] = ent_filled_r[i];
      end
    end
  end

  // Pointer, counter and PC next-state, with the redirect taking priority
  always_comb begin
    tail_nxt_s = tail_r + PW'(fetch_fire_s);
    head_nxt_s = head_r;
    occ_nxt_s  = occ_r;
    pend_nxt_s = pend_r;
    drop_nxt_s = drop_r;
    pc_nxt_s   = pc_r;
    if (redirect_s) begin
      // Every unfilled entry and a same-cycle request become wrong-path
      // responses; a same-cycle fill already retired one of them.
      head_nxt_s = tail_nxt_s;
      occ_nxt_s  = {CW{1'b0}};
      pend_nxt_s = {CW{1'b0}};
      drop_nxt_s = drop_r - CW'(rsp_drop_s) + pend_r + CW'(fetch_fire_s) - CW'(rsp_fill_s);
      pc_nxt_s   = target_s;
    end else begin
      head_nxt_s = head_r + PW'(pop_s);
      occ_nxt_s  = occ_r + CW'(fetch_fire_s) - CW'(pop_s);
      pend_nxt_s = pend_r + CW'(fetch_fire_s) - CW'(rsp_fill_s);
      drop_nxt_s = drop_r - CW'(rsp_drop_s);
      if (fetch_fire_s) begin
        pc_nxt_s = pc_r + PC_STEP;
      end else begin
        pc_nxt_s = pc_r;
      end
    end
  end

  // State registers and buffer writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_r[i] <= {RV_PC_SIZE{1'b0}};
        ent_ir_r[i] <= {RV_IR_SIZE{1'b0}};
      end
      ent_filled_r <= {DEPTH{1'b0}};
      head_r       <= {PW{1'b0}};
      tail_r       <= {PW{1'b0}};
      occ_r        <= {CW{1'b0}};
      pend_r       <= {CW{1'b0}};
      drop_r       <= {CW{1'b0}};
      pc_r         <= RESET_PC;
    end else begin
      if (fetch_fire_s) begin
        ent_pc_r[tail_r] <= pc_r;
      end
      if (rsp_fill_s) begin
        ent_ir_r[fill_idx_s] <= ifetch.rsp_ir;
      end
      ent_filled_r <= filled_nxt_s;
      head_r       <= head_nxt_s;
      tail_r       <= tail_nxt_s;
      occ_r        <= occ_nxt_s;
      pend_r       <= pend_nxt_s;
      drop_r       <= drop_nxt_s;
      pc_r         <= pc_nxt_s;
    end
  end

endmodule
